// File: rtl/xor_cipher_cfg_loader.sv
// Collects a 131-bit cipher config image as bytes, scans it LSB-first into the cipher, then asserts run.
// Latency: SHIFT starts on the edge after byte 16; 131 cfg_en cycles (262 with CFG_LOADER_VERIFY_EN readback).
// Backpressure: in_ready low during SHIFT/VERIFY/DONE, so a held in_valid simply stalls.
module xor_cipher_cfg_loader #(
  parameter int CFG_BITS = 131
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       cfg_en,
  output logic       cfg_i,
  input  logic       cfg_o,
  output logic       run,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int N_BYTES = (CFG_BITS + 7) / 8;
  localparam int PAD_BITS = 8 * N_BYTES;
  localparam logic [4:0] LAST_BYTE = 5'(N_BYTES - 1);
  localparam logic [7:0] LAST_BIT = 8'(CFG_BITS - 1);

`ifdef CFG_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SHIFT, VERIFY, DONE, RUN} state_t;
`else
  typedef enum logic [2:0] {IDLE, SHIFT, DONE, RUN} state_t;
`endif

  state_t                state_q, state_d;
  logic [4:0]            byte_cnt_q;
  logic [7:0]            bit_cnt_q;
  logic [CFG_BITS-1:0]   image_q;
  logic [PAD_BITS-1:0]   image_wr;
  logic [PAD_BITS-CFG_BITS-1:0] unused_pad;
  logic                  accept;
  logic                  last_byte;
  logic                  last_bit;

  assign accept    = in_valid & in_ready;
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_bit  = (bit_cnt_q == LAST_BIT);

  // Byte 16 only carries three real bits; the padding absorbs the rest.
  always_comb begin
    image_wr = PAD_BITS'(image_q);
    if (accept) begin
      image_wr[8*byte_cnt_q +: 8] = in_data;
    end
  end
  assign unused_pad = image_wr[PAD_BITS-1:CFG_BITS];

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cfg_en   = 1'b0;
    run      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && last_byte) state_d = SHIFT;
      end
      SHIFT: begin
        cfg_en = 1'b1;
        busy   = 1'b1;
        if (last_bit) begin
`ifdef CFG_LOADER_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CFG_LOADER_VERIFY_EN
      VERIFY: begin
        cfg_en = 1'b1;
        busy   = 1'b1;
        if (last_bit) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        run     = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        run      = 1'b1;
        in_ready = 1'b1;
        // The final byte hands the cipher back to the scan chain on the same edge.
        if (in_valid && last_byte) state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
    cfg_i = cfg_en ? image_q[bit_cnt_q] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      image_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        image_q    <= image_wr[CFG_BITS-1:0];
        byte_cnt_q <= last_byte ? 5'd0 : byte_cnt_q + 5'd1;
      end
      if (cfg_en) begin
        bit_cnt_q <= last_bit ? 8'd0 : bit_cnt_q + 8'd1;
      end
    end
  end

`ifdef CFG_LOADER_VERIFY_EN
  logic err_q;

  // During readback the cipher's bit 0 should echo the bit being re-sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && byte_cnt_q == 5'd0) begin
      err_q <= 1'b0;
    end else if (state_q == VERIFY && cfg_o != image_q[bit_cnt_q]) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_cfg_o;
  assign unused_cfg_o = cfg_o;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xor_cipher_cfg_loader.sv
// Directed bench for xor_cipher_cfg_loader with a shift-register cipher model.
module tb_xor_cipher_cfg_loader;

`ifdef CFG_LOADER_VERIFY_EN
  localparam int LOAD_CYC = 262;
  localparam int VDONES   = 2;
`else
  localparam int LOAD_CYC = 131;
  localparam int VDONES   = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       cfg_en;
  logic       cfg_i;
  logic       cfg_o;
  logic       run;
  logic       busy;
  logic       done;
  logic       err;

  logic [130:0] cip;
  logic [130:0] snap;
  logic [130:0] rec_bits;
  logic         force_zero;
  int           en_run, last_len, viol, overlap, done_cnt;
  int           n_checks, n_errors;

  always #5 clk = ~clk;

  xor_cipher_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o), .run(run), .busy(busy), .done(done), .err(err)
  );

  // Cipher scan chain: bit 0 first in, ends at bit 0 after 131 shifts.
  always @(posedge clk) begin
    if (cfg_en) cip <= {cfg_i, cip[130:1]};
  end
  assign cfg_o = force_zero ? 1'b0 : cip[0];

  always @(negedge clk) begin
    if (cfg_en) begin
      if (en_run < 131) rec_bits[en_run] <= cfg_i;
      en_run <= en_run + 1;
      if (in_ready) viol <= viol + 1;
      if (run) overlap <= overlap + 1;
    end else if (en_run != 0) begin
      last_len <= en_run;
      en_run   <= 0;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      snap     <= cip;
    end
  end

  task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("in_ready_timeout", 131'(in_ready), 131'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_range(input logic [135:0] raw, input int first, input int last, input bit gaps);
    for (int j = first; j <= last; j++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(raw[8*j +: 8]);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("done_timeout", 131'(done), 131'(1));
    @(negedge clk);
  endtask

  logic [130:0] img1, img2, img_b, img_c;
  logic [135:0] raw_a5;

  initial begin
    img1   = {3'b001, 64'h0000_0000_4800_0000, 64'h0000_0000_0000_0055};
    img2   = {3'b100, 64'h8000_0000_0000_000D, 64'h0F0F_0F0F_0F0F_0F0E};
    img_b  = {3'b110, 64'hDEAD_BEEF_0123_4567, 64'h0123_4567_89AB_CDEF};
    img_c  = {3'b011, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0001};
    raw_a5 = {17{8'hA5}};
    n_checks = 0; n_errors = 0;
    en_run = 0; last_len = 0; viol = 0; overlap = 0; done_cnt = 0;
    cip = '0; snap = '0; rec_bits = '0; force_zero = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    rst_n = 1'b0;

    #1;
    check("rst_outputs", 131'({in_ready, cfg_en, cfg_i, run, busy, done, err}), 131'(7'b1000000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference image: d_en=1, taps 0x48000000, state 0x55.
    send_range({5'b0, img1}, 0, 16, 1'b0);
    check("t1_shift_start", 131'({cfg_en, busy, in_ready}), 131'(3'b110));
    wait_done();
    check("t1_len", 131'(last_len), 131'(LOAD_CYC));
    check("t1_seq", rec_bits, img1);
    check("t1_cipher", cip, img1);
    check("t1_done_cnt", 131'(done_cnt), 131'(1));
    check("t1_run", 131'({run, busy, in_ready, err}), 131'(4'b1010));

    // Randomly gapped 0xA5 bytes; byte 16 keeps only its low three bits.
    send_range(raw_a5, 0, 16, 1'b1);
    wait_done();
    check("a5_cipher", cip, raw_a5[130:0]);
    check("a5_seq", rec_bits, raw_a5[130:0]);
    check("a5_len", 131'(last_len), 131'(LOAD_CYC));
    check("a5_ready_in_shift", 131'(viol), 131'(0));

`ifdef CFG_LOADER_VERIFY_EN
    force_zero = 1'b1;
    send_range({5'b0, img1}, 0, 16, 1'b0);
    wait_done();
    force_zero = 1'b0;
    check("v_err_set", 131'(err), 131'(1));
    send_range({5'b0, img2}, 0, 0, 1'b0);
    check("v_err_clear", 131'(err), 131'(0));
    send_range({5'b0, img2}, 1, 16, 1'b0);
    wait_done();
    check("v_err_stays0", 131'(err), 131'(0));
    check("v_cipher", cip, img2);
`endif

    // Asynchronous reset in the middle of a shift.
    send_range({5'b0, img2}, 0, 16, 1'b0);
    repeat (60) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", 131'({cfg_en, run, busy, in_ready, done}), 131'(5'b00010));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_range({5'b0, img1}, 0, 16, 1'b0);
    wait_done();
    check("rl_len", 131'(last_len), 131'(LOAD_CYC));
    check("rl_cipher", cip, img1);
    check("rl_run", 131'(run), 131'(1));

    // Reload from RUN, then a second image held against the busy loader.
    send_range({5'b0, img_b}, 0, 15, 1'b1);
    check("run_thru_b15", 131'({run, cfg_en}), 131'(2'b10));
    send_range({5'b0, img_b}, 16, 16, 1'b0);
    check("run_to_shift", 131'({run, cfg_en}), 131'(2'b01));
    send_range({5'b0, img_c}, 0, 16, 1'b0);
    check("b_snapshot", snap, img_b);
    wait_done();
    check("c_cipher", cip, img_c);
    check("overlap", 131'(overlap), 131'(0));
    check("ready_in_shift", 131'(viol), 131'(0));
    check("done_total", 131'(done_cnt), 131'(5 + VDONES));
    check("final_err", 131'(err), 131'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
